// File: rtl/pdm_mic_emulator.sv
// PCM-to-PDM microphone emulator: sample FIFO, IDLE/RUN priming FSM, OSR step
// counter and first-order sigma-delta modulator stepped on a chosen mic_clk edge.
module pdm_mic_emulator #(
  parameter int OSR           = 64,
  parameter int FIFO_DEPTH    = 8,
  parameter int PRIME_LEVEL   = 4,
  parameter int DRIVE_ON_FALL = 1
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                mic_clk_in,
  input  logic signed [15:0]                  pcm_in,
  input  logic                                pcm_valid_in,
  output logic                                pcm_ready_out,
  output logic                                mic_data_out,
  output logic                                running_out,
  output logic                                underflow_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fill_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH+1);
  localparam int SW = $clog2(OSR);
  localparam bit STEP_ON_FALL = (DRIVE_ON_FALL != 0);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                mic_prev_q;
  logic                step_evt;
  logic [SW-1:0]       step_q;
  logic signed [15:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]       fill_q;
  logic                full, empty, push, load, pop;
  logic signed [15:0]  cur_q;
  logic signed [15:0]  mod_in;
  logic signed [17:0]  acc_q, sum, acc_next;
  logic                pdm_bit;
  logic                mic_data_q, underflow_q;

  assign step_evt = STEP_ON_FALL ? (mic_prev_q & ~mic_clk_in) : (~mic_prev_q & mic_clk_in);

  // Handshake: a sample transfers on any cycle where pcm_valid_in and
  // pcm_ready_out are both high; the producer holds pcm_in until then.
  assign full          = (fill_q == FW'(FIFO_DEPTH));
  assign empty         = (fill_q == '0);
  assign pcm_ready_out = !rst_in && !full;
  assign push          = pcm_valid_in && pcm_ready_out;
  assign load          = (state_q == RUN) && step_evt && (step_q == '0);
  assign pop           = load && !empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_q >= FW'(PRIME_LEVEL)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // A load with an empty FIFO keeps replaying the last sample.
  always_comb begin
    mod_in = '0;
    if (state_q == RUN) mod_in = pop ? mem[rd_ptr_q] : cur_q;
  end

  assign sum      = acc_q + {{2{mod_in[15]}}, mod_in};
  assign pdm_bit  = ~sum[17];
  assign acc_next = pdm_bit ? (sum - 18'sd32767) : (sum + 18'sd32768);

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr_q] <= pcm_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      mic_prev_q  <= 1'b0;
      step_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      cur_q       <= '0;
      acc_q       <= '0;
      mic_data_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mic_prev_q  <= mic_clk_in;
      underflow_q <= load && empty;
      fill_q      <= fill_q + FW'(push) - FW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        cur_q    <= mem[rd_ptr_q];
      end
      if (step_evt) begin
        acc_q      <= acc_next;
        mic_data_q <= pdm_bit;
        if (state_q == RUN)
          step_q <= (step_q == SW'(OSR-1)) ? '0 : step_q + SW'(1);
      end
    end
  end

  assign mic_data_out  = mic_data_q;
  assign underflow_out = underflow_q;
  assign running_out   = (state_q == RUN);
  assign fill_out      = fill_q;

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Bench for pdm_mic_emulator: directed step table on OSR=4 instances (both edge
// polarities) plus randomized run of a default instance against a queue model.
module tb_pdm_mic_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        mic_clk;
  logic [15:0] pcm;
  logic        pcm_valid;

  logic       ready_a, data_a, run_a, uf_a;
  logic       ready_b, data_b, run_b, uf_b;
  logic       ready_c, data_c, run_c, uf_c;
  logic [3:0] fill_a, fill_b, fill_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pdm_mic_emulator #(.OSR(4), .FIFO_DEPTH(8), .PRIME_LEVEL(1), .DRIVE_ON_FALL(1)) dut_a (
    .clk_in(clk), .rst_in(rst), .mic_clk_in(mic_clk), .pcm_in(pcm), .pcm_valid_in(pcm_valid),
    .pcm_ready_out(ready_a), .mic_data_out(data_a), .running_out(run_a),
    .underflow_out(uf_a), .fill_out(fill_a));

  pdm_mic_emulator #(.OSR(4), .FIFO_DEPTH(8), .PRIME_LEVEL(1), .DRIVE_ON_FALL(0)) dut_b (
    .clk_in(clk), .rst_in(rst), .mic_clk_in(mic_clk), .pcm_in(pcm), .pcm_valid_in(pcm_valid),
    .pcm_ready_out(ready_b), .mic_data_out(data_b), .running_out(run_b),
    .underflow_out(uf_b), .fill_out(fill_b));

  pdm_mic_emulator #(.OSR(64), .FIFO_DEPTH(8), .PRIME_LEVEL(4), .DRIVE_ON_FALL(1)) dut_c (
    .clk_in(clk), .rst_in(rst), .mic_clk_in(mic_clk), .pcm_in(pcm), .pcm_valid_in(pcm_valid),
    .pcm_ready_out(ready_c), .mic_data_out(data_c), .running_out(run_c),
    .underflow_out(uf_c), .fill_out(fill_c));

  typedef struct {
    bit do_push;
    int pcm;
    bit exp_bit;
    bit exp_uf;
    int exp_fill;
  } row_t;

  row_t rows[17];

  // Reference model of dut_c: FIFO as a queue, modulator in plain integers.
  localparam int M_OSR = 64, M_DEPTH = 8, M_PRIME = 4;
  int m_q[$];
  int m_acc = 0, m_cur = 0, m_step = 0;
  bit m_run = 0, m_bit = 0, m_uf = 0, m_prev = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit mic, input bit v, input int d);
    int fill0, x, sum;
    bit e;
    if (r) begin
      m_q.delete();
      m_acc = 0; m_cur = 0; m_step = 0;
      m_run = 0; m_bit = 0; m_uf = 0; m_prev = 0;
      return;
    end
    e = m_prev && !mic;
    fill0 = m_q.size();
    m_uf = 0;
    if (m_run && e && m_step == 0) begin
      if (fill0 > 0) m_cur = m_q.pop_front();
      else m_uf = 1;
    end
    if (e) begin
      x = m_run ? m_cur : 0;
      sum = m_acc + x;
      m_bit = (sum >= 0);
      m_acc = m_bit ? sum - 32767 : sum + 32768;
      if (m_run) m_step = (m_step + 1) % M_OSR;
    end
    if (v && fill0 < M_DEPTH) m_q.push_back(d);
    if (!m_run && fill0 >= M_PRIME) m_run = 1;
    m_prev = mic;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic silence(input int half, input int periods);
    for (int k = 0; k < periods; k++) begin
      mic_clk = 1'b1;
      repeat (half) @(negedge clk);
      mic_clk = 1'b0;
      repeat (half) @(negedge clk);
      check("silence_bit_a", data_a, (k % 2 == 0));
      check("silence_bit_b", data_b, (k % 2 == 0));
      check("silence_bit_c", data_c, (k % 2 == 0));
      check("silence_run_a", run_a, 0);
      check("silence_run_c", run_c, 0);
      check("silence_fill_a", fill_a, 0);
      check("silence_fill_c", fill_c, 0);
      check("silence_ready_c", ready_c, 1);
    end
  endtask

  initial begin
    int pa, pb, acc_cnt, first, d;
    bit r, v;

    rows[0]  = '{1, 32767, 1, 0, 0};
    rows[1]  = '{0, 0, 1, 0, 0};
    rows[2]  = '{0, 0, 1, 0, 0};
    rows[3]  = '{0, 0, 1, 0, 0};
    rows[4]  = '{1, -32768, 0, 0, 0};
    rows[5]  = '{0, 0, 0, 0, 0};
    rows[6]  = '{0, 0, 0, 0, 0};
    rows[7]  = '{0, 0, 0, 0, 0};
    rows[8]  = '{1, 16384, 1, 0, 0};
    rows[9]  = '{0, 0, 1, 0, 0};
    rows[10] = '{0, 0, 0, 0, 0};
    rows[11] = '{0, 0, 1, 0, 0};
    rows[12] = '{0, 0, 1, 1, 0};
    rows[13] = '{0, 0, 1, 0, 0};
    rows[14] = '{0, 0, 0, 0, 0};
    rows[15] = '{0, 0, 1, 0, 0};
    rows[16] = '{0, 0, 1, 1, 0};

    rst = 1'b1; mic_clk = 1'b0; pcm = '0; pcm_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_a", ready_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_run_a", run_a, 0);
    check("rst_uf_a", uf_a, 0);
    check("rst_fill_a", fill_a, 0);
    check("rst_data_c", data_c, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_a", ready_a, 1);
    check("post_rst_ready_c", ready_c, 1);

    silence(16, 6);

    // Step table on the OSR=4 pair: full scale, then single-sample underflow.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (rows[i].do_push) begin
        pcm = 16'(rows[i].pcm);
        pcm_valid = 1'b1;
        @(negedge clk);
        pcm_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      pa = data_a; pb = data_b;
      mic_clk = 1'b1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check("edge_a_hold_on_rise", data_a, pa);
        if (j > 0) check("edge_b_hold", data_b, pb);
        if (j == 0) check("uf_b", uf_b, rows[i].exp_uf);
        if (j == 1) check("uf_b_pulse_end", uf_b, 0);
        pb = data_b;
      end
      check("bit_b", data_b, rows[i].exp_bit);
      mic_clk = 1'b0;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check("edge_b_hold_on_fall", data_b, pb);
        if (j > 0) check("edge_a_hold", data_a, pa);
        if (j == 0) check("uf_a", uf_a, rows[i].exp_uf);
        if (j == 1) check("uf_a_pulse_end", uf_a, 0);
        pa = data_a;
      end
      check("bit_a", data_a, rows[i].exp_bit);
      check("fill_a", fill_a, rows[i].exp_fill);
      check("fill_b", fill_b, rows[i].exp_fill);
      check("run_a", run_a, 1);
    end

    // Backpressure on the default instance with mic_clk stopped.
    do_reset();
    acc_cnt = 0; first = 0;
    pcm_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 65535)) - 32768;
      pcm = 16'(d);
      #1;
      if (ready_c) begin
        if (acc_cnt == 0) first = d;
        acc_cnt++;
      end
      @(negedge clk);
    end
    pcm_valid = 1'b0;
    check("bp_accepted", acc_cnt, 8);
    check("bp_fill_full", fill_c, 8);
    check("bp_ready_low", ready_c, 0);
    mic_clk = 1'b1;
    repeat (2) @(negedge clk);
    mic_clk = 1'b0;
    @(negedge clk);
    check("bp_fill_after_load", fill_c, 7);
    check("bp_ready_after_load", ready_c, 1);
    check("bp_run", run_c, 1);
    check("bp_first_bit", data_c, (first >= 0));

    // Reset in the middle of RUN with samples queued and acc nonzero.
    do_reset();
    pcm = 16'd1000;
    pcm_valid = 1'b1;
    repeat (6) @(negedge clk);
    pcm_valid = 1'b0;
    repeat (2) @(negedge clk);
    mic_clk = 1'b1;
    repeat (2) @(negedge clk);
    mic_clk = 1'b0;
    @(negedge clk);
    check("mid_fill", fill_a, 5);
    check("mid_run", run_a, 1);
    check("mid_bit", data_a, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", ready_a, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_fill", fill_a, 0);
    check("mid_rst_run", run_a, 0);
    check("mid_rst_bit", data_a, 0);
    silence(4, 4);

    // Randomized run of the default instance against the model.
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        check("rnd_bit", data_c, m_bit);
        check("rnd_run", run_c, m_run);
        check("rnd_uf", uf_c, m_uf);
        check("rnd_fill", fill_c, m_q.size());
      end
      r = (cyc == 0) || ($urandom_range(0, 2999) == 0);
      if (cyc < 4000) v = ($urandom_range(0, 99) < 5);
      else v = ($urandom_range(0, 999) < 2);
      case ($urandom_range(0, 7))
        0:       d = 32767;
        1:       d = -32768;
        default: d = int'($urandom_range(0, 65535)) - 32768;
      endcase
      if ($urandom_range(0, 2) == 0) mic_clk = ~mic_clk;
      rst = r;
      pcm_valid = v;
      pcm = 16'(d);
      #1;
      check("rnd_ready", ready_c, (!r && m_q.size() < M_DEPTH));
      model_step(r, mic_clk, v, d);
    end
    @(negedge clk);
    rst = 1'b0;
    pcm_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_mic_emulator.md
Name: pdm_mic_emulator

Overview:
- Transmit-side twin of the PDM microphone path: accepts signed 16-bit PCM samples over a valid/ready handshake and drives a 1-bit PDM stream on mic_data_out, clocked by the mic clock the design already generates.
- Used for loopback into the fir_decimator chain and as a deterministic microphone stand-in for bench and on-board tests.
- Contains a small sample FIFO, an IDLE/RUN priming state machine, an OSR step counter, and a first-order sigma-delta modulator.

Parameters:
- OSR, 64: mic-clock steps per PCM sample. Must be at least 2.
- FIFO_DEPTH, 8: PCM sample FIFO depth. Power of two, at least 2.
- PRIME_LEVEL, 4: FIFO fill needed to leave IDLE. Range 1..FIFO_DEPTH.
- DRIVE_ON_FALL, 1: 1 = step on falling mic_clk edge; 0 = step on rising edge.

Ports:
- clk_in  input  1  system clock (clk_m domain).
- rst_in  input  1  reset.
- mic_clk_in  input  1  mic clock, generated in the clk_in domain; synchronous, so no synchronizer.
- pcm_in  input  16  signed PCM sample.
- pcm_valid_in  input  1  pcm_in valid.
- pcm_ready_out  output  1  FIFO can accept a sample.
- mic_data_out  output  1  PDM bit.
- running_out  output  1  high in RUN state.
- underflow_out  output  1  single-cycle pulse: load needed, FIFO empty.
- fill_out  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Clocking and reset:
  - Single clock clk_in.
  - Reset is synchronous, active-high on rst_in.
  - Reset state: mic_data_out=0, running_out=0, underflow_out=0, fill_out=0, accumulator=0, current sample=0, step counter=0, mic_clk history register=0, state=IDLE.
  - pcm_ready_out = !rst_in && (fill < FIFO_DEPTH), combinational.
- Step event E:
  - Active edge of mic_clk_in, detected by comparing it with the registered previous value.
  - DRIVE_ON_FALL=1: prev=1, now=0. DRIVE_ON_FALL=0: prev=0, now=1.
  - E is high for exactly one clk_in cycle per mic clock period.
- FIFO:
  - Push when pcm_valid_in && pcm_ready_out. While full, pcm_valid_in is ignored and the sample is not lost from the producer's view, because ready is low.
  - Pop happens only at a load (below).
  - Push and pop in the same cycle: fill unchanged.
  - Push while empty: no same-cycle bypass. A simultaneous load sees empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - fill_out is registered and reflects the post-update count.
- State machine:
  - IDLE: modulator input forced to 0, step counter held at 0, no pops. IDLE -> RUN on the first cycle where fill >= PRIME_LEVEL; the transition takes effect next cycle.
  - RUN: on E with step counter == 0, load. If FIFO is non-empty, pop its head into the current sample. If empty, hold the previous sample and pulse underflow_out on that cycle. The loaded or held value is used by the modulator in the same E cycle.
  - Step counter increments on each E in RUN and wraps at OSR-1 back to 0.
  - RUN stays RUN on underflow; only rst_in returns to IDLE.
- Modulator, evaluated on E only:
  - x = modulator input, signed 16-bit; acc is signed 18-bit.
  - sum = acc + x; bit = (sum >= 0).
  - acc <= sum - (bit ? 32767 : -32768).
  - acc stays within [-32768, 32767]; no saturation logic is needed.
  - Latency: mic_data_out <= bit is registered on E, so it is visible the cycle after E and held until the next E. It is therefore stable at the receiver's opposite-edge sample point.
- Reset asserted mid-stream: the FIFO is flushed, queued samples are discarded, and the block returns to IDLE with every register at its reset value in the next cycle.

Test Plan:
- Silence pattern: reset, then toggle mic_clk_in at period 32 cycles with no pushes.
  - Required: IDLE holds.
  - mic_data_out is 1,0,1,0,... per E, starting 1 on the first E after reset.
  - pcm_ready_out=1, fill_out=0, running_out=0.
- Full scale, OSR=4, PRIME_LEVEL=1:
  - Push +32767 -> after RUN entry, every bit is 1 for 4 steps, acc=0 throughout.
  - Then push -32768 -> next 4 bits are all 0.
- Backpressure, FIFO_DEPTH=8, with mic_clk_in stopped and pcm_valid_in held high:
  - Required: exactly 8 samples accepted, fill_out=8, pcm_ready_out=0, and the 9th sample is not accepted.
  - Start mic_clk_in -> the first load pops one sample, fill_out=7, pcm_ready_out=1 the same cycle.
- Underflow, PRIME_LEVEL=1, OSR=4:
  - Push a single sample of 16384 -> in RUN, the second load finds the FIFO empty.
  - Required: underflow_out pulses for exactly 1 cycle on that E, 16384 is held, and bit density stays at 75%.
- Edge select: DRIVE_ON_FALL=0 vs 1 with the same stimulus.
  - Required: mic_data_out changes only on the cycle after a rising edge vs after a falling edge, respectively.
- Reset mid-RUN with fill_out=5 and acc nonzero: pulse rst_in for 1 cycle.
  - Required: next cycle fill_out=0, running_out=0, mic_data_out=0.
  - The subsequent silence pattern restarts at 1,0,1,0.
